// File: rtl/integrator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : integrator_scheduler
// Description : Round-robin sequencer that shares one two-phase trapezoidal
//               integrator engine between NUM_CH sample channels.
// Revision    : 1.0 - initial release
// ============================================================================
module integrator_scheduler #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic [NUM_CH-1:0]        clr,
  output logic [NUM_CH-1:0]        ack,
  output logic                     eng_clk_en,
  output logic                     eng_start,
  output logic [DATA_W-1:0]        eng_dataa,
  output logic [DATA_W-1:0]        eng_datab,
  input  logic                     eng_done,
  input  logic [DATA_W-1:0]        eng_result,
  output logic [NUM_CH*DATA_W-1:0] acc_out,
  output logic                     out_valid,
  output logic [2:0]               out_ch,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  RR_RST   = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              kill_q, kill_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] acc_q   [NUM_CH];
  logic [DATA_W-1:0] prev_q  [NUM_CH];
  logic [NUM_CH-1:0] first_q;

  logic [DATA_W-1:0] samp_w  [NUM_CH];
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic              wr_upd;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign samp_w[gi]                    = sample_in[gi*DATA_W +: DATA_W];
      assign acc_out[gi*DATA_W +: DATA_W] = acc_q[gi];
    end
  endgenerate

  // Search starts one past the last served channel so every requester gets a turn.
  always_comb begin
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!grant_vld && req[CH_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(cand);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rr_d     = rr_q;
    sample_d = sample_q;
    result_d = result_q;
    timer_d  = timer_q;
    kill_d   = kill_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          ch_d     = grant_ch;
          sample_d = samp_w[grant_ch];
          kill_d   = clr[grant_ch];
          timer_d  = '0;
          state_d  = first_q[grant_ch] ? S_WRITE : S_PRIME;
        end
      end
      S_PRIME: begin
        timer_d = '0;
        kill_d  = kill_q | clr[ch_q];
        state_d = S_RUN;
      end
      S_RUN: begin
        kill_d = kill_q | clr[ch_q];
        if (eng_done) begin
          result_d = eng_result;
          state_d  = S_WRITE;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          rr_d    = ch_q;
          kill_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WRITE: begin
        rr_d    = ch_q;
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      rr_q     <= RR_RST;
      sample_q <= '0;
      result_q <= '0;
      timer_q  <= '0;
      kill_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      rr_q     <= rr_d;
      sample_q <= sample_d;
      result_q <= result_d;
      timer_q  <= timer_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
    end
  end

  // A clear always wins over the write-back of an op on the same channel.
  assign wr_upd = (state_q == S_WRITE) && !kill_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]  <= '0;
        prev_q[i] <= '0;
      end
      first_q <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr[i]) begin
          acc_q[i]   <= '0;
          prev_q[i]  <= '0;
          first_q[i] <= 1'b1;
        end else if (wr_upd && (int'(ch_q) == i)) begin
          prev_q[i] <= sample_q;
          if (first_q[i]) first_q[i] <= 1'b0;
          else            acc_q[i]   <= result_q;
        end
      end
    end
  end

  always_comb begin
    eng_dataa = '0;
    eng_datab = '0;
    case (state_q)
      S_PRIME: eng_dataa = prev_q[ch_q];
      S_RUN: begin
        eng_dataa = sample_q;
        eng_datab = acc_q[ch_q];
      end
      default: begin
        eng_dataa = '0;
        eng_datab = '0;
      end
    endcase
  end

  assign ack         = ((state_q == S_IDLE) && grant_vld && !reset) ? (NUM_CH'(1) << grant_ch) : '0;
  assign eng_clk_en  = (state_q == S_PRIME) || (state_q == S_RUN);
  assign eng_start   = eng_clk_en;
  assign out_valid   = wr_upd && !clr[ch_q];
  assign out_ch      = 3'(ch_q);
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_integrator_scheduler.sv
`default_nettype none
// Bench for integrator_scheduler: directed stimulus, op-timeline reference
// model with an embedded engine, plus literal expectations.
module tb_integrator_scheduler;

  localparam int NC = 3;
  localparam int DW = 32;
  localparam int TO = 64;

  logic             clk;
  logic             reset;
  logic [NC-1:0]    req;
  logic [NC*DW-1:0] sample_in;
  logic [NC-1:0]    clr;
  logic [NC-1:0]    ack;
  logic             eng_clk_en;
  logic             eng_start;
  logic [DW-1:0]    eng_dataa;
  logic [DW-1:0]    eng_datab;
  logic             eng_done;
  logic [DW-1:0]    eng_result;
  logic [NC*DW-1:0] acc_out;
  logic             out_valid;
  logic [2:0]       out_ch;
  logic             busy;
  logic             err_timeout;

  integrator_scheduler #(.NUM_CH(NC), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .sample_in  (sample_in),
    .clr        (clr),
    .ack        (ack),
    .eng_clk_en (eng_clk_en),
    .eng_start  (eng_start),
    .eng_dataa  (eng_dataa),
    .eng_datab  (eng_datab),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .acc_out    (acc_out),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Stimulus knobs
  int            cyc;
  logic [NC-1:0] req_v;
  logic [NC-1:0] clr_v;
  logic [DW-1:0] smp_v [NC];
  int            eng_k;     // engine latency into RUN; -1 = never answers
  bit            stray_en;

  // Reference model state
  logic [DW-1:0] m_acc  [NC];
  logic [DW-1:0] m_prev [NC];
  bit            m_first[NC];
  int            m_rr;
  bit            m_err;
  bit            op_act;
  int            op_g;
  int            op_ch;
  bit            op_first;
  bit            op_kill;
  logic [DW-1:0] op_smp;
  logic [DW-1:0] op_old;
  logic [DW-1:0] op_res;

  // Observations
  int ov_cnt;
  int last_ov_d;
  int start_cnt;
  int ack_log[$];
  int exp_order[6] = '{0, 1, 2, 0, 1, 2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic m_reset();
    for (int i = 0; i < NC; i++) begin
      m_acc[i]   = '0;
      m_prev[i]  = '0;
      m_first[i] = 1'b1;
    end
    m_rr   = NC - 1;
    m_err  = 1'b0;
    op_act = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_eng_clk_en"}, eng_clk_en, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_dataa"}, eng_dataa, 0);
    chk({tag, "_eng_datab"}, eng_datab, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_ch"}, out_ch, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    for (int i = 0; i < NC; i++) chk($sformatf("%s_acc_out[%0d]", tag, i), acc_out[i*DW +: DW], 0);
  endtask

  // One clock cycle: drive inputs, predict outputs from the op timeline,
  // compare at the falling edge, then commit the end-of-cycle effects.
  task automatic cycle();
    int            d;
    int            run_len;
    logic [NC-1:0] e_ack;
    bit            e_en, e_start, e_busy, e_write, e_tmo, e_ov;
    logic [DW-1:0] e_a, e_b;
    @(posedge clk);
    #1;
    cyc++;
    req = req_v;
    clr = clr_v;
    for (int i = 0; i < NC; i++) sample_in[i*DW +: DW] = smp_v[i];
    eng_done   = 1'b0;
    eng_result = '0;
    d = -1; e_ack = '0; e_en = 0; e_start = 0; e_busy = 0; e_write = 0; e_tmo = 0; e_ov = 0;
    e_a = '0; e_b = '0;
    if (!op_act) begin
      for (int k = 1; k <= NC; k++) begin
        int idx;
        idx = (m_rr + k) % NC;
        if (!op_act && req_v[idx]) begin
          op_act   = 1'b1;
          op_g     = cyc;
          op_ch    = idx;
          op_smp   = smp_v[idx];
          op_first = m_first[idx];
          op_kill  = 1'b0;
        end
      end
      if (!op_act && stray_en) begin
        eng_done   = 1'b1;
        eng_result = 32'hDEAD_BEEF;
      end
    end
    if (op_act) begin
      d = cyc - op_g;
      op_kill = op_kill | clr_v[op_ch];
      if (d == 0) begin
        e_ack = NC'(1 << op_ch);
      end else begin
        e_busy = 1'b1;
        if (op_first) begin
          e_write = 1'b1;
        end else if (d == 1) begin
          e_en = 1; e_start = 1;
          e_a    = m_prev[op_ch];
          op_old = m_prev[op_ch];
        end else begin
          run_len = (eng_k >= 0 && eng_k < TO) ? eng_k + 1 : TO;
          if (d < 2 + run_len) begin
            e_en = 1; e_start = 1;
            e_a = op_smp;
            e_b = m_acc[op_ch];
            if (d == 2 + eng_k) begin
              eng_done   = 1'b1;
              eng_result = m_acc[op_ch] + (op_smp + op_old) / 2;
              op_res     = eng_result;
            end else if (d == 1 + TO) begin
              e_tmo = 1'b1;
            end
          end else begin
            e_write = 1'b1;
          end
        end
      end
      e_ov = e_write && !op_kill;
    end

    @(negedge clk);
    chk("ack", ack, e_ack);
    chk("eng_clk_en", eng_clk_en, e_en);
    chk("eng_start", eng_start, e_start);
    chk("eng_dataa", eng_dataa, e_a);
    chk("eng_datab", eng_datab, e_b);
    chk("busy", busy, e_busy);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) chk("out_ch", out_ch, 3'(op_ch));
    chk("err_timeout", err_timeout, m_err);
    for (int i = 0; i < NC; i++) chk($sformatf("acc_out[%0d]", i), acc_out[i*DW +: DW], m_acc[i]);
    if (out_valid) begin
      ov_cnt++;
      last_ov_d = d;
    end
    if (eng_start) start_cnt++;
    for (int i = 0; i < NC; i++) if (ack[i]) ack_log.push_back(i);

    if (e_write && !op_kill) begin
      m_prev[op_ch] = op_smp;
      if (op_first) m_first[op_ch] = 1'b0;
      else          m_acc[op_ch]   = op_res;
    end
    if (e_tmo) m_err = 1'b1;
    if (e_write || e_tmo) begin
      m_rr   = op_ch;
      op_act = 1'b0;
    end
    for (int i = 0; i < NC; i++) begin
      if (clr_v[i]) begin
        m_acc[i]   = '0;
        m_prev[i]  = '0;
        m_first[i] = 1'b1;
      end
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    req_v = '0; clr_v = '0; eng_k = 1; stray_en = 0;
    for (int i = 0; i < NC; i++) smp_v[i] = '0;
    reset = 1'b1; req = '0; clr = '0; sample_in = '0; eng_done = 1'b0; eng_result = '0;
    m_reset();
    #2;
    chk_reset_outputs("rst");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First sample on ch0: straight to write-back, no engine activity.
    smp_v[0] = 100; req_v = 3'b001; start_cnt = 0; last_ov_d = -1;
    cycle();
    req_v = '0;
    repeat (3) cycle();
    chk("t1_ov_latency", last_ov_d, 1);
    chk("t1_acc0", acc_out[31:0], 0);
    chk("t1_no_start", start_cnt, 0);

    // Second ch0 sample through the engine, done one cycle into RUN.
    smp_v[0] = 300; req_v = 3'b001; eng_k = 1; last_ov_d = -1;
    cycle();
    req_v = '0;
    repeat (6) cycle();
    chk("t2_ov_latency", last_ov_d, 4);
    chk("t2_acc0", acc_out[31:0], 200);

    // Engine never answers on ch0 while ch1 waits.
    smp_v[0] = 500; smp_v[1] = 70; eng_k = -1; req_v = 3'b001;
    cycle();
    req_v = 3'b010; start_cnt = 0; ov_cnt = 0;
    repeat (65) cycle();
    chk("t4_start_cycles", start_cnt, 65);
    chk("t4_no_out_valid", ov_cnt, 0);
    eng_k = 1;
    cycle();
    chk("t4_next_grant", ack_log[ack_log.size()-1], 1);
    chk("t4_err_sticky", err_timeout, 1);
    req_v = '0;
    repeat (3) cycle();
    chk("t4_acc0_kept", acc_out[31:0], 200);

    // Clear ch1 while its op sits in RUN.
    smp_v[1] = 90; eng_k = 3; req_v = 3'b010;
    cycle();
    req_v = '0; ov_cnt = 0;
    repeat (2) cycle();
    clr_v = 3'b010;
    cycle();
    clr_v = '0;
    repeat (6) cycle();
    chk("t5_no_out_valid", ov_cnt, 0);
    chk("t5_acc1", acc_out[63:32], 0);
    smp_v[1] = 33; req_v = 3'b010; last_ov_d = -1;
    cycle();
    req_v = '0;
    repeat (3) cycle();
    chk("t5_first_again", last_ov_d, 1);

    // Engine done pulses while idle must be ignored.
    stray_en = 1;
    repeat (3) cycle();
    stray_en = 0;

    // Reset in the middle of RUN on ch0.
    smp_v[0] = 600; eng_k = 10; req_v = 3'b001;
    cycle();
    req_v = '0;
    repeat (4) cycle();
    #2;
    reset = 1'b1; req = '0; clr = '0; eng_done = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    m_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All channels requesting continuously: strict rotation from ch0.
    smp_v[0] = 10; smp_v[1] = 20; smp_v[2] = 30; eng_k = 1;
    ack_log.delete();
    req_v = 3'b111;
    repeat (30) cycle();
    req_v = '0;
    repeat (8) cycle();
    chk("rr_grant_count", ack_log.size() >= 6, 1);
    for (int i = 0; i < 6; i++) if (i < ack_log.size()) chk($sformatf("rr_order[%0d]", i), ack_log[i], exp_order[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
